fetch_stage: RTL and testbench

//  IF stage of the 16-bit pipelined CPU: owns the PC, drives instruction memory port 1,

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage of the 16-bit pipelined CPU: owns the PC, drives instruction memory port 1,
// predicts the next PC with a direct-mapped BTB plus 2-bit counters, and loads the IF/ID latch.
module fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   BTB_IDX   = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    output logic                 readM1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_taken,
    output logic [WORD_SIZE-1:0] if_id_instruction,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic [WORD_SIZE-1:0] if_id_pred_pc,
    output logic                 if_id_valid
);

    localparam int ENTRIES = 1 << BTB_IDX;
    localparam int TAG_W   = WORD_SIZE - BTB_IDX;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // ------------------------------------------------------------------
    // PC and IF/ID state
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] pc_reg;
    logic [WORD_SIZE-1:0] pc_next;
    logic [WORD_SIZE-1:0] inst_reg;
    logic [WORD_SIZE-1:0] id_pc_reg;
    logic [WORD_SIZE-1:0] id_pred_reg;
    logic                 id_valid_reg;

    // ------------------------------------------------------------------
    // BTB storage: per-entry registers, gathered into read arrays
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0]   valid_vec;
    logic [TAG_W-1:0]     tag_arr    [ENTRIES];
    logic [WORD_SIZE-1:0] target_arr [ENTRIES];
    logic [1:0]           ctr_arr    [ENTRIES];

    logic [BTB_IDX-1:0]   look_idx;
    logic [TAG_W-1:0]     look_tag;
    logic                 look_hit;
    logic [WORD_SIZE-1:0] pc_plus1;

    logic [BTB_IDX-1:0]   upd_idx;
    logic [TAG_W-1:0]     upd_tag;

    assign look_idx = pc_reg[BTB_IDX-1:0];
    assign look_tag = pc_reg[WORD_SIZE-1:BTB_IDX];
    assign upd_idx  = upd_pc[BTB_IDX-1:0];
    assign upd_tag  = upd_pc[WORD_SIZE-1:BTB_IDX];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_btb
            logic                 valid_reg;
            logic [TAG_W-1:0]     tag_reg;
            logic [WORD_SIZE-1:0] target_reg;
            logic [1:0]           ctr_reg;
            logic                 sel;
            logic                 entry_hit;

            assign sel       = upd_valid && (upd_idx == BTB_IDX'(gi));
            assign entry_hit = valid_reg && (tag_reg == upd_tag);

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= 2'b01;
                end else if (sel) begin
                    if (entry_hit) begin
                        ctr_reg <= upd_taken ? ctr_inc(ctr_reg) : ctr_dec(ctr_reg);
                        if (upd_taken) begin
                            target_reg <= upd_target;
                        end
                    end else if (upd_taken) begin
                        // Fresh allocation starts weakly taken
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= upd_target;
                        ctr_reg    <= 2'b10;
                    end
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
            assign ctr_arr[gi]    = ctr_reg;
        end
    endgenerate

    // Lookup reads the registered entry, so a same-cycle update is not visible yet
    assign look_hit = valid_vec[look_idx] && (tag_arr[look_idx] == look_tag);
    assign pc_plus1 = pc_reg + WORD_SIZE'(1);
    assign pc_next  = (look_hit && ctr_arr[look_idx][1]) ? target_arr[look_idx] : pc_plus1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg       <= RESET_PC;
            inst_reg     <= '0;
            id_pc_reg    <= '0;
            id_pred_reg  <= '0;
            id_valid_reg <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg       <= redirect_pc;
            inst_reg     <= '0;
            id_pc_reg    <= '0;
            id_pred_reg  <= '0;
            id_valid_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg       <= pc_next;
            inst_reg     <= data1;
            id_pc_reg    <= pc_reg;
            id_pred_reg  <= pc_next;
            id_valid_reg <= 1'b1;
        end
    end

    assign readM1            = ~Reset;
    assign address1          = pc_reg;
    assign if_id_instruction = inst_reg;
    assign if_id_pc          = id_pc_reg;
    assign if_id_pred_pc     = id_pred_reg;
    assign if_id_valid       = id_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table of inputs and expected outputs,
// followed by a hand-written BTB counter saturation / same-cycle update sequence.
module tb_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic        readM1;
    logic [15:0] address1;
    logic [15:0] data1;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic [15:0] if_id_instruction;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pred_pc;
    logic        if_id_valid;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_stage #(.WORD_SIZE(16), .BTB_IDX(4), .RESET_PC(16'h0)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .readM1            (readM1),
        .address1          (address1),
        .data1             (data1),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_target        (upd_target),
        .upd_taken         (upd_taken),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_pred_pc     (if_id_pred_pc),
        .if_id_valid       (if_id_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory model: word depends on the address
    assign data1 = address1 ^ 16'hA5A5;

    typedef struct {
        logic        rst, st, rv;
        logic [15:0] rpc;
        logic        uv;
        logic [15:0] upc, utgt;
        logic        ut;
        logic        chk, rd;
        logic [15:0] addr;
        logic        val;
        logic [15:0] ipc, ipred, inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic st, logic rv, logic [15:0] rpc,
                                logic uv, logic [15:0] upc, logic [15:0] utgt, logic ut,
                                logic chk, logic rd, logic [15:0] addr, logic val,
                                logic [15:0] ipc, logic [15:0] ipred, logic [15:0] inst);
        vec_t v;
        v.rst = rst; v.st = st; v.rv = rv; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut;
        v.chk = chk; v.rd = rd; v.addr = addr; v.val = val;
        v.ipc = ipc; v.ipred = ipred; v.inst = inst;
        return v;
    endfunction

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic idle_inputs();
        Reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        upd_valid = 1'b0; upd_pc = 16'h0; upd_target = 16'h0; upd_taken = 1'b0;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;

        //              rst st rv rpc      uv upc    utgt     ut  chk rd addr     val ipc      ipred    inst
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0001, 1, 16'h0000, 16'h0001, 16'hA5A5));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0002, 1, 16'h0001, 16'h0002, 16'hA5A4));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5, 16'h0014, 1,  1, 1, 16'h0003, 1, 16'h0002, 16'h0003, 16'hA5A7));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0004, 1, 16'h0003, 16'h0004, 16'hA5A6));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0005, 1, 16'h0004, 16'h0005, 16'hA5A1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5, 16'h0000, 0,  1, 1, 16'h0014, 1, 16'h0005, 16'h0014, 16'hA5A0));
        vecs.push_back(mk(0, 0, 1, 16'h0005, 1, 16'h5, 16'h0000, 0,  1, 1, 16'h0015, 1, 16'h0014, 16'h0015, 16'hA5B1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0006, 1, 16'h0005, 16'h0006, 16'hA5A0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0007, 1, 16'h0006, 16'h0007, 16'hA5A3));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h5, 16'h0030, 1,  1, 1, 16'h0008, 1, 16'h0007, 16'h0008, 16'hA5A2));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h5, 16'h0030, 1,  1, 1, 16'h0008, 1, 16'h0007, 16'h0008, 16'hA5A2));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0008, 1, 16'h0007, 16'h0008, 16'hA5A2));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0008, 1, 16'h0007, 16'h0008, 16'hA5A2));
        vecs.push_back(mk(0, 0, 1, 16'h0005, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0009, 1, 16'h0008, 16'h0009, 16'hA5AD));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 1, 1, 16'h0040, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0030, 1, 16'h0005, 16'h0030, 16'hA5A0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'hFFFF, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0041, 1, 16'h0040, 16'h0041, 16'hA5E5));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 16'h0040, 0, 16'h0, 16'h0000, 0,  1, 0, 16'h0000, 1, 16'hFFFF, 16'h0000, 16'h5A5A));
        vecs.push_back(mk(0, 0, 1, 16'h0005, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0, 16'h0000, 0,  1, 1, 16'h0006, 1, 16'h0005, 16'h0006, 16'hA5A0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            Reset = vecs[i].rst; stall = vecs[i].st;
            redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
            upd_target = vecs[i].utgt; upd_taken = vecs[i].ut;
            #1;
            if (vecs[i].chk) begin
                n_vec++;
                if (readM1 !== vecs[i].rd || address1 !== vecs[i].addr || if_id_valid !== vecs[i].val ||
                    if_id_pc !== vecs[i].ipc || if_id_pred_pc !== vecs[i].ipred ||
                    if_id_instruction !== vecs[i].inst) begin
                    n_miss++;
                    $display("FAIL vec%0d: got rd=%b addr=%h val=%b pc=%h pred=%h inst=%h, expected rd=%b addr=%h val=%b pc=%h pred=%h inst=%h",
                             i, readM1, address1, if_id_valid, if_id_pc, if_id_pred_pc, if_id_instruction,
                             vecs[i].rd, vecs[i].addr, vecs[i].val, vecs[i].ipc, vecs[i].ipred, vecs[i].inst);
                end else begin
                    $display("ok   vec%0d: addr=%h val=%b pc=%h pred=%h inst=%h",
                             i, address1, if_id_valid, if_id_pc, if_id_pred_pc, if_id_instruction);
                end
            end
        end

        // Counter saturation at 11 and lookup-before-update on the same index (pc=7)
        @(negedge Clk); idle_inputs(); stall = 1'b1;
        upd_valid = 1'b1; upd_pc = 16'h0007; upd_target = 16'h0050; upd_taken = 1'b1;   // alloc -> 10
        @(negedge Clk);                                                                   // -> 11
        @(negedge Clk);                                                                   // stays 11
        @(negedge Clk); upd_taken = 1'b0;                                                 // -> 10
        @(negedge Clk); idle_inputs(); redirect_valid = 1'b1; redirect_pc = 16'h0007;
        @(negedge Clk); idle_inputs();
        upd_valid = 1'b1; upd_pc = 16'h0007; upd_taken = 1'b0;                            // -> 01 at this edge
        #1; chk16("sat_at_pc7", address1, 16'h0007);
        @(negedge Clk); idle_inputs(); redirect_valid = 1'b1; redirect_pc = 16'h0007;
        #1; chk16("pre_update_lookup_addr", address1, 16'h0050);
        chk16("pre_update_lookup_pred", if_id_pred_pc, 16'h0050);
        chk16("pre_update_lookup_pc", if_id_pc, 16'h0007);
        @(negedge Clk); idle_inputs();
        #1; chk16("weak_nt_at_pc7", address1, 16'h0007);
        @(negedge Clk);
        #1; chk16("weak_nt_next_addr", address1, 16'h0008);
        chk16("weak_nt_pred", if_id_pred_pc, 16'h0008);

        // Same index, different tag: no hit
        @(negedge Clk); redirect_valid = 1'b1; redirect_pc = 16'h0017;
        @(negedge Clk); idle_inputs();
        #1; chk16("tag_miss_at_17", address1, 16'h0017);
        @(negedge Clk);
        #1; chk16("tag_miss_next", address1, 16'h0018);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
